// File: rtl/axis_width_downconverter.sv
// axis_width_downconverter: unpacks one wide AXI-Stream beat into RATIO narrow beats, lane 0 first.
// Define AXIS_DOWNCONV_TKEEP_EN to add s_axis_tkeep; lanes with keep=0 are skipped without idle cycles.
module axis_width_downconverter #(
  parameter int DATA_WIDTH = 16,
  parameter int RATIO = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [DATA_WIDTH*RATIO-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
`ifdef AXIS_DOWNCONV_TKEEP_EN
  input  logic [RATIO-1:0]            s_axis_tkeep,
`endif
  output logic                        s_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready
);
  localparam int IW = RATIO > 1 ? $clog2(RATIO) : 1;
  logic [DATA_WIDTH*RATIO-1:0] r_data;
  logic r_last, r_valid, last_lane, s_acc, m_hs, load_valid;
  logic [IW-1:0] r_idx, nxt_idx, first_idx;
`ifdef AXIS_DOWNCONV_TKEEP_EN
  logic [RATIO-1:0] r_keep;
  // Downward scans leave the lowest qualifying lane as the winner.
  always_comb begin
    nxt_idx = r_idx;
    last_lane = 1'b1;
    first_idx = '0;
    for (int i = RATIO - 1; i >= 0; i--) begin
      if (i > int'(r_idx) && r_keep[i]) begin
        nxt_idx = IW'(i);
        last_lane = 1'b0;
      end
      if (s_axis_tkeep[i]) first_idx = IW'(i);
    end
  end
  assign load_valid = |s_axis_tkeep;
`else
  assign last_lane = r_idx == IW'(RATIO - 1);
  assign nxt_idx = r_idx + 1'b1;
  assign first_idx = '0;
  assign load_valid = 1'b1;
`endif
  assign m_hs = r_valid && m_axis_tready;
  assign s_axis_tready = aresetn && (!r_valid || (m_axis_tready && last_lane));
  assign s_acc = s_axis_tvalid && s_axis_tready;
  assign m_axis_tvalid = r_valid;
  assign m_axis_tdata = r_data[r_idx*DATA_WIDTH +: DATA_WIDTH];
  assign m_axis_tlast = r_last && last_lane;
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_valid <= 1'b0;
      r_idx <= '0;
      r_last <= 1'b0;
      r_data <= '0;
`ifdef AXIS_DOWNCONV_TKEEP_EN
      r_keep <= '0;
`endif
    end else if (s_acc) begin
      r_data <= s_axis_tdata;
      r_last <= s_axis_tlast;
      r_valid <= load_valid;
      r_idx <= first_idx;
`ifdef AXIS_DOWNCONV_TKEEP_EN
      r_keep <= s_axis_tkeep;
`endif
    end else if (m_hs) begin
      r_idx <= last_lane ? '0 : nxt_idx;
      r_valid <= !last_lane;
    end
  end
endmodule

// File: tb/tb_axis_width_downconverter.sv
// tb_axis_width_downconverter: randomized and directed checks of the down-converter against a lane-queue model.
module tb_axis_width_downconverter;
  logic aclk, aresetn;
  logic [63:0] s_data;
  logic s_valid, s_last, s_ready, m_valid, m_last, m_rdy;
  logic [15:0] m_data;
  logic [15:0] s_data1, m_data1;
  logic s_valid1, s_last1, s_ready1, m_valid1, m_last1, m_rdy1;
  logic [3:0] s_keep;
  int tests = 0, fails = 0;
  logic [16:0] q[$];
  logic [16:0] q1[$];
  logic rst_done;
  logic [3:0] kv;
  logic er, er1;

  axis_width_downconverter #(.DATA_WIDTH(16), .RATIO(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last),
`ifdef AXIS_DOWNCONV_TKEEP_EN
    .s_axis_tkeep(s_keep),
`endif
    .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tlast(m_last), .m_axis_tready(m_rdy)
  );

  axis_width_downconverter #(.DATA_WIDTH(16), .RATIO(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_data1), .s_axis_tvalid(s_valid1), .s_axis_tlast(s_last1),
`ifdef AXIS_DOWNCONV_TKEEP_EN
    .s_axis_tkeep(1'b1),
`endif
    .s_axis_tready(s_ready1),
    .m_axis_tdata(m_data1), .m_axis_tvalid(m_valid1), .m_axis_tlast(m_last1), .m_axis_tready(m_rdy1)
  );

  initial begin
    aclk = 0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%h expected=%h at %0t", n, a, e, $time);
    end
  endtask

  always @(posedge aclk) rst_done <= !aresetn;

  // Model: queue holds the narrow beats still owed from the stored wide beat.
  always @(negedge aclk) begin
    er = aresetn && (q.size() == 0 || (q.size() == 1 && m_rdy));
    chk("s_tready", s_ready, er);
    chk("m_tvalid", m_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("m_tdata", m_data, q[0][15:0]);
      chk("m_tlast", m_last, q[0][16]);
    end else if (rst_done) begin
      chk("rst_tdata", m_data, 0);
      chk("rst_tlast", m_last, 0);
    end
    er1 = aresetn && (q1.size() == 0 || m_rdy1);
    chk("r1_tready", s_ready1, er1);
    chk("r1_tvalid", m_valid1, q1.size() != 0);
    if (q1.size() != 0) begin
      chk("r1_tdata", m_data1, q1[0][15:0]);
      chk("r1_tlast", m_last1, q1[0][16]);
    end
    if (!aresetn) begin
      q.delete();
      q1.delete();
    end else begin
`ifdef AXIS_DOWNCONV_TKEEP_EN
      kv = s_keep;
`else
      kv = 4'hf;
`endif
      if (q.size() != 0 && m_rdy) void'(q.pop_front());
      if (s_valid && er)
        for (int k = 0; k < 4; k++)
          if (kv[k]) q.push_back({s_last && ((kv >> (k + 1)) == 0), s_data[k*16 +: 16]});
      if (q1.size() != 0 && m_rdy1) void'(q1.pop_front());
      if (s_valid1 && er1) q1.push_back({s_last1, s_data1});
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic pin(input logic [15:0] d, input logic l, input logic r);
    @(negedge aclk);
    chk("pin_valid", m_valid, 1);
    chk("pin_data", m_data, d);
    chk("pin_last", m_last, l);
    chk("pin_ready", s_ready, r);
    step();
  endtask

  task automatic send(input logic [63:0] d, input logic l);
    s_data = d;
    s_last = l;
    s_valid = 1;
    step();
    s_valid = 0;
  endtask

  initial begin
    forever begin
      @(posedge aclk);
      #1;
      s_valid1 = $urandom_range(0, 9) < 6;
      s_data1 = 16'($urandom);
      s_last1 = 1'($urandom);
      m_rdy1 = $urandom_range(0, 9) < 6;
    end
  end

  initial begin
    aresetn = 0;
    s_data = '0; s_valid = 0; s_last = 0; s_keep = 4'hf; m_rdy = 1;
    s_data1 = '0; s_valid1 = 0; s_last1 = 0; m_rdy1 = 0;
    repeat (3) step();
    aresetn = 1;
    send(64'h4444_3333_2222_1111, 1);
    pin(16'h1111, 0, 0); pin(16'h2222, 0, 0); pin(16'h3333, 0, 0); pin(16'h4444, 1, 1);
    s_data = 64'h4444_3333_2222_1111; s_last = 0; s_valid = 1;
    step();
    s_data = 64'h8888_7777_6666_5555; s_last = 1;
    pin(16'h1111, 0, 0); pin(16'h2222, 0, 0); pin(16'h3333, 0, 0); pin(16'h4444, 0, 1);
    s_valid = 0;
    pin(16'h5555, 0, 0); pin(16'h6666, 0, 0); pin(16'h7777, 0, 0); pin(16'h8888, 1, 1);
    send(64'h4444_3333_2222_1111, 0);
    pin(16'h1111, 0, 0);
    m_rdy = 0;
    repeat (5) pin(16'h2222, 0, 0);
    m_rdy = 1;
    pin(16'h2222, 0, 0); pin(16'h3333, 0, 0); pin(16'h4444, 0, 1);
    send(64'h4444_3333_2222_1111, 1);
    pin(16'h1111, 0, 0); pin(16'h2222, 0, 0);
    aresetn = 0;
    step();
    aresetn = 1;
    @(negedge aclk);
    chk("post_rst_valid", m_valid, 0);
    step();
    send(64'hDDDD_CCCC_BBBB_AAAA, 0);
    pin(16'hAAAA, 0, 0); pin(16'hBBBB, 0, 0); pin(16'hCCCC, 0, 0); pin(16'hDDDD, 0, 1);
`ifdef AXIS_DOWNCONV_TKEEP_EN
    s_keep = 4'b0101;
    send(64'h4444_3333_2222_1111, 1);
    pin(16'h1111, 0, 0); pin(16'h3333, 1, 1);
    s_keep = 4'b0000;
    send(64'h4444_3333_2222_1111, 1);
    @(negedge aclk);
    chk("zero_keep_valid", m_valid, 0);
    chk("zero_keep_ready", s_ready, 1);
    step();
    s_keep = 4'hf;
`endif
    for (int c = 0; c < 3000; c++) begin
      aresetn = $urandom_range(0, 299) != 0;
      s_valid = $urandom_range(0, 9) < 6;
      s_data = {$urandom, $urandom};
      s_last = 1'($urandom);
      m_rdy = $urandom_range(0, 9) < 7;
`ifdef AXIS_DOWNCONV_TKEEP_EN
      s_keep = ($urandom_range(0, 3) == 0) ? 4'hf : 4'($urandom);
`endif
      step();
    end
    @(negedge aclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axis_width_downconverter.md
Name: axis_width_downconverter

Overview:
- AXI-Stream width down-converter: accepts one wide beat of RATIO lanes and emits RATIO narrow beats of DATA_WIDTH bits, least-significant lane first.
- Sits directly upstream of axis_skid_buffer and feeds it. The skid buffer registers the combinational tready path this block exposes.
- Typical use: unpacking wide DMA/FIFO words onto a narrow processing stream.

Parameters:
- DATA_WIDTH, 16: narrow (output) lane width in bits.
- RATIO, 4: lanes per wide beat. Must be >= 1. Input width is DATA_WIDTH*RATIO.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; synchronous, active-low.
- s_axis_tdata  in  DATA_WIDTH*RATIO  wide input data; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tvalid  in  1  wide beat valid.
- s_axis_tlast  in  1  wide beat ends packet.
- s_axis_tready  out  1  wide beat accepted when tvalid && tready.
- m_axis_tdata  out  DATA_WIDTH  narrow output data.
- m_axis_tvalid  out  1  narrow beat valid.
- m_axis_tlast  out  1  narrow beat ends packet.
- m_axis_tready  in  1  downstream ready.
- s_axis_tkeep  in  RATIO  per-lane keep. Present only with AXIS_DOWNCONV_TKEEP_EN.

Behaviour:
- State: holding register r_data (wide), r_last, r_valid, lane index r_idx (width clog2(RATIO), min 1). With the feature enabled, also r_keep.
- Reset (aresetn=0 at posedge): r_valid=0, r_idx=0, r_last=0, r_data=0. Outputs m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0. s_axis_tready=0 while aresetn=0.
- m_axis_tvalid = r_valid.
- m_axis_tdata = lane r_idx of r_data.
- m_axis_tlast = r_last && (r_idx is final lane).
- No combinational path from any s_axis_* input to any m_axis_* output.
- last_lane = (r_idx == RATIO-1).
- s_axis_tready = aresetn && (!r_valid || (m_axis_tready && last_lane)).
- Input accept: r_data, r_last, r_valid=1 and r_idx=0 load at the clock edge.
- Latency: lane 0 appears on m_axis the cycle after the wide beat is accepted.
- Narrow handshake (m_axis_tvalid && m_axis_tready):
  - If not last_lane: r_idx increments.
  - If last_lane: r_idx=0, and r_valid clears unless a new wide beat is accepted in the same cycle.
- Simultaneous final-lane handshake and new input accept: new beat loads and r_valid stays 1. No bubble. Sustained throughput is 1 narrow beat per cycle.
- Backpressure (m_axis_tready=0): m_axis_tdata/tlast/tvalid are held stable; r_idx does not advance.
- RATIO=1: block is a single-register pipeline stage. s_axis_tready = !r_valid || m_axis_tready.
- Reset mid-beat: the partially emitted wide beat is discarded and no further lanes are output. After release, the first output is lane 0 of the next accepted beat.
- tlast is never asserted on a non-final lane.

Optional Feature:
- Macro: AXIS_DOWNCONV_TKEEP_EN.
- Defined:
  - s_axis_tkeep port exists and is captured into r_keep.
  - Lanes with keep=0 are skipped: r_idx advances to the next set keep bit. The skip is a combinational priority search, so no idle cycles are spent on skipped lanes.
  - last_lane = no higher set keep bit above r_idx.
  - m_axis_tlast asserts on the last kept lane of a tlast beat.
  - An all-zero-keep beat is accepted and dropped; its tlast is discarded.
- Undefined: no s_axis_tkeep port; all lanes are emitted.

Test Plan:
- DATA_WIDTH=16, RATIO=4, m_axis_tready=1. One beat 0x4444_3333_2222_1111 with tlast=1 -> m_axis_tdata 0x1111, 0x2222, 0x3333, 0x4444 on 4 consecutive cycles starting 1 cycle after accept. tlast only on 0x4444.
- Two back-to-back beats (0x..._1111, 0x..._5555), tvalid held -> 8 narrow beats in 8 consecutive cycles. s_axis_tready high exactly in the cycle 0x4444 handshakes.
- Hold m_axis_tready=0 for 5 cycles while showing 0x2222 -> outputs stable, s_axis_tready=0. Release -> 0x3333, 0x4444 follow with no loss or duplication.
- Assert aresetn=0 for 1 cycle after 0x2222 is emitted -> m_axis_tvalid=0 the next cycle, 0x3333/0x4444 never appear. The next accepted beat starts at lane 0.
- RATIO=1, random tvalid/tready, 200 beats -> output sequence equals input sequence. tlast preserved. Never more than 1 beat stored.
- With AXIS_DOWNCONV_TKEEP_EN: keep=4'b0101, tlast=1 -> outputs 0x1111 then 0x3333 (tlast) on consecutive cycles. keep=4'b0000 -> no output and s_axis_tready returns high the next cycle.
